// File: rtl/median9_sort_sched.sv
// median9_sort_sched: 3x3 median via three passes through a shared external 3-input sorter.
// Column sort, then min-of-max / med-of-med / max-of-min, then the median of those three.
module median9_sort_sched #(
  parameter int SORT_LAT = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [7:0]  iPix0,
  input  logic [7:0]  iPix1,
  input  logic [7:0]  iPix2,
  input  logic [7:0]  iPix3,
  input  logic [7:0]  iPix4,
  input  logic [7:0]  iPix5,
  input  logic [7:0]  iPix6,
  input  logic [7:0]  iPix7,
  input  logic [7:0]  iPix8,
  input  logic        iValid,
  output logic        oReady,
  output logic [7:0]  oSortA,
  output logic [7:0]  oSortB,
  output logic [7:0]  oSortC,
  input  logic [7:0]  iSortMin,
  input  logic [7:0]  iSortMed,
  input  logic [7:0]  iSortMax,
  output logic [7:0]  oMedian,
  output logic        oValid,
  input  logic        iReady,
  output logic        oBusy,
  output logic [15:0] oWinCount
);
  typedef enum logic [2:0] {IDLE, S1_ISSUE, S1_WAIT, S2_ISSUE, S2_WAIT, S3_ISSUE, S3_WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] pix_q [9];
  logic [7:0] pix_d [9];
  logic [3:0] tag_q [SORT_LAT];
  logic [3:0] tag_d [SORT_LAT];
  logic [7:0] mn_q [3];
  logic [7:0] mn_d [3];
  logic [7:0] md_q [3];
  logic [7:0] md_d [3];
  logic [7:0] mx_q [3];
  logic [7:0] mx_d [3];
  logic [7:0] mom_q, mom_d, mem_q, mem_d, xom_q, xom_d;
  logic [7:0] median_q, median_d;
  logic valid_q, valid_d;
  logic [15:0] win_count_q, win_count_d;
  logic issue, hs, s3_cap;
  logic [2:0] code;
  logic [3:0] cap, idx;
  // Tag = {valid, code}; codes 0-2 column sort, 4-6 second pass, 7 final median
  assign cap = tag_q[SORT_LAT-1];
  assign s3_cap = cap == 4'b1111;
  assign hs = state_q == DONE && iReady;
  assign idx = {2'b00, cnt_q};
  assign oMedian = median_q;
  assign oValid = valid_q;
  assign oWinCount = win_count_q;
  always_ff @(posedge iClk) begin
    if (iRst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = 2'd0;
    case (state_q)
      IDLE:     state_d = iValid ? S1_ISSUE : IDLE;
      S1_ISSUE: begin
        state_d = cnt_q == 2'd2 ? S1_WAIT : S1_ISSUE;
        cnt_d = cnt_q == 2'd2 ? 2'd0 : cnt_q + 2'd1;
      end
      S1_WAIT:  state_d = cap == 4'b1010 ? S2_ISSUE : S1_WAIT;
      S2_ISSUE: begin
        state_d = cnt_q == 2'd2 ? S2_WAIT : S2_ISSUE;
        cnt_d = cnt_q == 2'd2 ? 2'd0 : cnt_q + 2'd1;
      end
      S2_WAIT:  state_d = cap == 4'b1110 ? S3_ISSUE : S2_WAIT;
      S3_ISSUE: state_d = S3_WAIT;
      S3_WAIT:  state_d = s3_cap ? DONE : S3_WAIT;
      DONE:     state_d = iReady ? IDLE : DONE;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    oReady = state_q == IDLE;
    oBusy = state_q != IDLE;
    issue = state_q == S1_ISSUE || state_q == S2_ISSUE || state_q == S3_ISSUE;
    code = state_q == S1_ISSUE ? {1'b0, cnt_q} : state_q == S2_ISSUE ? {1'b1, cnt_q} : 3'b111;
    {oSortA, oSortB, oSortC} =
      state_q == S1_ISSUE ? {pix_q[idx], pix_q[idx + 4'd3], pix_q[idx + 4'd6]} :
      state_q == S2_ISSUE ? (cnt_q == 2'd0 ? {mx_q[0], mx_q[1], mx_q[2]} :
                             cnt_q == 2'd1 ? {md_q[0], md_q[1], md_q[2]} :
                                             {mn_q[0], mn_q[1], mn_q[2]}) :
      state_q == S3_ISSUE ? {mom_q, mem_q, xom_q} : 24'd0;
  end
  always_comb begin
    pix_d = pix_q;
    if (state_q == IDLE && iValid)
      pix_d = '{iPix0, iPix1, iPix2, iPix3, iPix4, iPix5, iPix6, iPix7, iPix8};
    tag_d[0] = issue ? {1'b1, code} : 4'd0;
    for (int i = 1; i < SORT_LAT; i++) tag_d[i] = tag_q[i-1];
    mn_d = mn_q;
    md_d = md_q;
    mx_d = mx_q;
    if (cap[3] && !cap[2]) begin
      mn_d[cap[1:0]] = iSortMin;
      md_d[cap[1:0]] = iSortMed;
      mx_d[cap[1:0]] = iSortMax;
    end
    mom_d = cap == 4'b1100 ? iSortMin : mom_q;
    mem_d = cap == 4'b1101 ? iSortMed : mem_q;
    xom_d = cap == 4'b1110 ? iSortMax : xom_q;
    median_d = s3_cap ? iSortMed : median_q;
    valid_d = s3_cap | (valid_q & ~hs);
    win_count_d = win_count_q + {15'd0, hs};
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q <= 2'd0;
      pix_q <= '{default: '0};
      tag_q <= '{default: '0};
      mn_q <= '{default: '0};
      md_q <= '{default: '0};
      mx_q <= '{default: '0};
      mom_q <= 8'd0;
      mem_q <= 8'd0;
      xom_q <= 8'd0;
      median_q <= 8'd0;
      valid_q <= 1'b0;
      win_count_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
      pix_q <= pix_d;
      tag_q <= tag_d;
      mn_q <= mn_d;
      md_q <= md_d;
      mx_q <= mx_d;
      mom_q <= mom_d;
      mem_q <= mem_d;
      xom_q <= xom_d;
      median_q <= median_d;
      valid_q <= valid_d;
      win_count_q <= win_count_d;
    end
  end
endmodule

// File: tb/tb_median9_sort_sched.sv
// tb_median9_sort_sched: directed bench for median9_sort_sched with behavioural sorters at latencies 2, 1 and 4.
module tb_median9_sort_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] pix [9];
  logic valid = 1'b0, ready = 1'b1, valid_x = 1'b0, ready_x = 1'b1;
  logic [23:0] ops0, ops1, ops4;
  logic [23:0] p2 [2];
  logic [23:0] p1 [1];
  logic [23:0] p4 [4];
  logic rdy0, rdy1, rdy4, val0, val1, val4, busy0, busy1, busy4;
  logic [7:0] med0, med1, med4;
  logic [15:0] cnt0, cnt1, cnt4;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [23:0] sort3(input logic [23:0] v);
    logic [7:0] a, b, c, lo, hi;
    {a, b, c} = v;
    lo = a < b ? a : b;
    hi = a < b ? b : a;
    if (c < lo) return {c, lo, hi};
    if (c > hi) return {lo, hi, c};
    return {lo, c, hi};
  endfunction

  always @(posedge clk) begin
    p2[0] <= sort3(ops0);
    p2[1] <= p2[0];
    p1[0] <= sort3(ops1);
    p4[0] <= sort3(ops4);
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end

  median9_sort_sched #(.SORT_LAT(2)) u0 (
    .iClk(clk), .iRst(rst),
    .iPix0(pix[0]), .iPix1(pix[1]), .iPix2(pix[2]), .iPix3(pix[3]), .iPix4(pix[4]),
    .iPix5(pix[5]), .iPix6(pix[6]), .iPix7(pix[7]), .iPix8(pix[8]),
    .iValid(valid), .oReady(rdy0),
    .oSortA(ops0[23:16]), .oSortB(ops0[15:8]), .oSortC(ops0[7:0]),
    .iSortMin(p2[1][23:16]), .iSortMed(p2[1][15:8]), .iSortMax(p2[1][7:0]),
    .oMedian(med0), .oValid(val0), .iReady(ready), .oBusy(busy0), .oWinCount(cnt0));

  median9_sort_sched #(.SORT_LAT(1)) u1 (
    .iClk(clk), .iRst(rst),
    .iPix0(pix[0]), .iPix1(pix[1]), .iPix2(pix[2]), .iPix3(pix[3]), .iPix4(pix[4]),
    .iPix5(pix[5]), .iPix6(pix[6]), .iPix7(pix[7]), .iPix8(pix[8]),
    .iValid(valid_x), .oReady(rdy1),
    .oSortA(ops1[23:16]), .oSortB(ops1[15:8]), .oSortC(ops1[7:0]),
    .iSortMin(p1[0][23:16]), .iSortMed(p1[0][15:8]), .iSortMax(p1[0][7:0]),
    .oMedian(med1), .oValid(val1), .iReady(ready_x), .oBusy(busy1), .oWinCount(cnt1));

  median9_sort_sched #(.SORT_LAT(4)) u4 (
    .iClk(clk), .iRst(rst),
    .iPix0(pix[0]), .iPix1(pix[1]), .iPix2(pix[2]), .iPix3(pix[3]), .iPix4(pix[4]),
    .iPix5(pix[5]), .iPix6(pix[6]), .iPix7(pix[7]), .iPix8(pix[8]),
    .iValid(valid_x), .oReady(rdy4),
    .oSortA(ops4[23:16]), .oSortB(ops4[15:8]), .oSortC(ops4[7:0]),
    .iSortMin(p4[3][23:16]), .iSortMed(p4[3][15:8]), .iSortMax(p4[3][7:0]),
    .oMedian(med4), .oValid(val4), .iReady(ready_x), .oBusy(busy4), .oWinCount(cnt4));

  function automatic logic [7:0] med9(input logic [7:0] w [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = w;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s[4];
  endfunction

  function automatic logic [71:0] gen_win(input int k);
    logic [71:0] v;
    for (int i = 0; i < 9; i++) v[71-8*i -: 8] = 8'((k * 53 + i * 97 + i * i * k * 11) & 255);
    return v;
  endfunction

  task automatic load(input logic [71:0] v);
    for (int i = 0; i < 9; i++) pix[i] = v[71-8*i -: 8];
  endtask

  // Presents one window to u0 from an idle state; returns edges from accept to oValid (-1 on timeout)
  task automatic run_window(input logic [71:0] v, output int edges, output logic [23:0] first_ops);
    load(v);
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    first_ops = ops0;
    edges = 0;
    while (!val0 && edges < 60) begin @(posedge clk); #1; edges++; end
    if (!val0) edges = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", val0); end
    checks++; if (med0 !== 8'h00) begin errors++; $display("FAIL reset_median got %h exp 00", med0); end
    checks++; if (cnt0 !== 16'h0000) begin errors++; $display("FAIL reset_count got %h exp 0000", cnt0); end
    checks++; if (ops0 !== 24'h0) begin errors++; $display("FAIL reset_ops got %h exp 000000", ops0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy0); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", rdy0); end
  endtask

  task automatic test_basic;
    int e;
    logic [23:0] fo;
    run_window(72'h010203040506070809, e, fo);
    checks++; if (e !== 13) begin errors++; $display("FAIL basic_latency got %0d exp 13", e); end
    checks++; if (med0 !== 8'd5) begin errors++; $display("FAIL basic_median got %0d exp 5", med0); end
    checks++; if (fo !== 24'h010407) begin errors++; $display("FAIL basic_first_ops got %h exp 010407", fo); end
    checks++; if (ops0 !== 24'h0 || busy0 !== 1'b1 || rdy0 !== 1'b0) begin errors++; $display("FAIL basic_done_outputs ops %h busy %0b ready %0b exp 000000 1 0", ops0, busy0, rdy0); end
    @(posedge clk); #1;
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL basic_valid_clear got %0b exp 0", val0); end
    checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", cnt0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %0b exp 1", rdy0); end
  endtask

  task automatic test_patterns;
    logic [71:0] wins [4];
    logic [7:0] exps [4];
    int e;
    logic [23:0] fo;
    wins = '{72'h090108020703060405, 72'hFFFFFFFFFFFFFFFFFF, 72'h00FF00FF00FF00FF80, 72'h030303010101020202};
    exps = '{8'd5, 8'hFF, 8'h80, 8'd2};
    for (int k = 0; k < 4; k++) begin
      run_window(wins[k], e, fo);
      if (k == 0) begin
        checks++; if (fo !== 24'h090206) begin errors++; $display("FAIL pattern_first_ops got %h exp 090206", fo); end
      end
      checks++; if (med0 !== exps[k]) begin errors++; $display("FAIL pattern%0d_median got %h exp %h", k, med0, exps[k]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int e;
    logic [23:0] fo;
    logic [15:0] c;
    ready = 1'b0;
    run_window(72'h010203040506070809, e, fo);
    c = cnt0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      checks++;
      if (val0 !== 1'b1 || med0 !== 8'd5 || rdy0 !== 1'b0 || cnt0 !== c) begin
        errors++; $display("FAIL hold_cycle%0d valid %0b median %0d ready %0b count %0d exp 1 5 0 %0d", n, val0, med0, rdy0, cnt0, c);
      end
    end
    ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %0b exp 0", val0); end
    checks++; if (cnt0 !== c + 16'd1) begin errors++; $display("FAIL hold_release_count got %0d exp %0d", cnt0, c + 16'd1); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %0b exp 1", rdy0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q [$];
    int acc = 0, got = 0, n = 0;
    valid = 1'b1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      load(gen_win(cyc));
      if (rdy0) begin exp_q.push_back(med9(pix)); acc++; end
      if (val0 && ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra_output got %h", med0); end
        else begin
          if (med0 !== exp_q[0]) begin errors++; $display("FAIL b2b_median%0d got %h exp %h", got, med0, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    while (exp_q.size() > 0 && n < 60) begin
      if (val0) begin
        checks++;
        if (med0 !== exp_q[0]) begin errors++; $display("FAIL b2b_median%0d got %h exp %h", got, med0, exp_q[0]); end
        void'(exp_q.pop_front());
        got++;
      end
      @(posedge clk); #1;
      n++;
    end
    checks++; if (acc !== 8) begin errors++; $display("FAIL b2b_accepted got %0d exp 8", acc); end
    checks++; if (got !== acc) begin errors++; $display("FAIL b2b_outputs got %0d exp %0d", got, acc); end
  endtask

  task automatic test_reset_mid;
    int e;
    logic [23:0] fo;
    bit seen = 1'b0;
    load(72'h010203040506070809);
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b1 || ops0 !== 24'h0) begin errors++; $display("FAIL midrst_wait_state busy %0b ops %h exp 1 000000", busy0, ops0); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL midrst_ready got %0b exp 1", rdy0); end
    repeat (20) begin @(posedge clk); #1; if (val0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_output got %0b exp 0", seen); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", cnt0); end
    run_window(72'h010203040506070809, e, fo);
    checks++; if (e !== 13 || med0 !== 8'd5) begin errors++; $display("FAIL midrst_next edges %0d median %0d exp 13 5", e, med0); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    int e;
    logic [23:0] fo;
    force u0.win_count_q = 16'hFFFF;
    @(posedge clk); #1;
    release u0.win_count_q;
    @(posedge clk); #1;
    checks++; if (cnt0 !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h exp FFFF", cnt0); end
    run_window(72'h010203040506070809, e, fo);
    @(posedge clk); #1;
    checks++; if (cnt0 !== 16'h0000) begin errors++; $display("FAIL wrap_count got %h exp 0000", cnt0); end
  endtask

  task automatic test_latency;
    int e1 = -1, e4 = -1;
    logic [7:0] m1 = 8'd0, m4 = 8'd0;
    load(72'h090108020703060405);
    valid_x = 1'b1;
    @(posedge clk); #1;
    valid_x = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (val1 && e1 < 0) begin e1 = n; m1 = med1; end
      if (val4 && e4 < 0) begin e4 = n; m4 = med4; end
    end
    checks++; if (e1 !== 10) begin errors++; $display("FAIL lat1_edges got %0d exp 10", e1); end
    checks++; if (e4 !== 19) begin errors++; $display("FAIL lat4_edges got %0d exp 19", e4); end
    checks++; if (m1 !== 8'd5) begin errors++; $display("FAIL lat1_median got %0d exp 5", m1); end
    checks++; if (m4 !== 8'd5) begin errors++; $display("FAIL lat4_median got %0d exp 5", m4); end
    checks++; if (cnt1 !== 16'd1 || cnt4 !== 16'd1) begin errors++; $display("FAIL lat_counts got %0d %0d exp 1 1", cnt1, cnt4); end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) pix[i] = 8'd0;
    test_reset;
    test_basic;
    test_patterns;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_wrap;
    test_latency;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/median9_sort_sched.md
MEDIAN9_SORT_SCHED -- requirements
Module: median9_sort_sched

Interface
REQ-001 SHALL have parameter SORT_LAT, default 2, meaning the sorter latency in clock edges from operand issue to result; legal values are 1..4.
REQ-002 SHALL have port iClk, input, 1 bit: single clock, all logic on its rising edge.
REQ-003 SHALL have port iRst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports iPix0..iPix8, input, 8 bits each: 3x3 window in row-major order; column k is {iPixk, iPix(k+3), iPix(k+6)}.
REQ-005 SHALL have port iValid, input, 1 bit: window valid.
REQ-006 SHALL have port oReady, output, 1 bit: window accepted when iValid and oReady are both high at a rising edge.
REQ-007 SHALL have ports oSortA, oSortB, oSortC, output, 8 bits each: operands driven to the shared external 3-input sorter.
REQ-008 SHALL have ports iSortMin, iSortMed, iSortMax, input, 8 bits each: sorter results.
REQ-009 SHALL have port oMedian, output, 8 bits: median of the 9 pixels.
REQ-010 SHALL have port oValid, output, 1 bit: oMedian valid.
REQ-011 SHALL have port iReady, input, 1 bit: downstream accepts oMedian when oValid and iReady are both high at an edge.
REQ-012 SHALL have port oBusy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port oWinCount, output, 16 bits: count of completed output handshakes; wraps 0xFFFF->0x0000.

Function
REQ-014 SHALL use the states IDLE, S1_ISSUE, S1_WAIT, S2_ISSUE, S2_WAIT, S3_ISSUE, S3_WAIT and DONE.
REQ-015 SHALL drive oReady high only in IDLE; an accepting edge registers all 9 pixels and enters S1_ISSUE.
REQ-016 SHALL ignore iValid in every state other than IDLE and leave the captured pixels unchanged.
REQ-017 S1_ISSUE SHALL last 3 cycles, issuing one column per cycle (column 0, then 1, then 2) on oSortA/B/C.
REQ-018 S2_ISSUE SHALL last 3 cycles, issuing in order: (max0,max1,max2) keeping iSortMin, (med0,med1,med2) keeping iSortMed, and (min0,min1,min2) keeping iSortMax.
REQ-019 S3_ISSUE SHALL last 1 cycle, issuing (minOfMax, medOfMed, maxOfMin) and keeping iSortMed as the median.
REQ-020 SHALL sample the result of an operand issued in cycle t from iSort* at the edge ending cycle t+SORT_LAT-1+1, i.e. SORT_LAT edges after the issue edge; results are tracked by a SORT_LAT-deep issue-tag shift register.
REQ-021 SHALL leave each WAIT state at the edge that captures the last result of its stage; the next ISSUE state begins the following cycle.
REQ-022 SHALL drive oSortA/B/C to 0 outside ISSUE states and ignore iSort* except at the tagged capture edges.
REQ-023 S3 capture SHALL load oMedian, set oValid and enter DONE; oValid rises 3*SORT_LAT+7 edges after the accepting edge (13 edges for SORT_LAT=2).
REQ-024 In DONE, oValid and oMedian SHALL be held stable until iReady is high; at that edge it SHALL clear oValid, increment oWinCount and return to IDLE.
REQ-025 SHALL permit no overlap between windows: at most one window in flight, and a new window is accepted no earlier than the cycle after the output handshake.
REQ-026 All comparisons SHALL be unsigned 8-bit; ties resolve to any equal value, so the result is value-identical.

Reset
REQ-027 iRst high at an edge SHALL force state IDLE, oValid=0, oMedian=0x00, oWinCount=0x0000, oSortA/B/C=0, clear the tag pipeline and clear captured data, with priority over all other inputs.
REQ-028 Reset mid-operation SHALL discard the in-flight window with no output produced; oReady SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-029 Pixels 1..9 accepted, iReady=1, SORT_LAT=2 -> oValid rises at edge 13, oMedian=5, oWinCount=1.
REQ-030 Window {9,1,8,2,7,3,6,4,5}, then a window of all 0xFF -> medians 5 then 0xFF; the first cycle of S1_ISSUE drives oSortA/B/C = 9,2,6.
REQ-031 iReady held 0 for 20 cycles after oValid -> oValid and oMedian stable, oReady=0, oWinCount unchanged; iReady=1 -> one handshake, then oReady=1 the next cycle.
REQ-032 iValid held high continuously with a new window each cycle -> only windows presented while oReady=1 are taken; one median per window with no corruption.
REQ-033 iRst pulsed during S2_WAIT -> no oValid pulse and oWinCount=0; the next window of 1..9 yields 5.
REQ-034 SORT_LAT=1 and SORT_LAT=4 regressions -> oValid at edges 10 and 19 respectively, with correct medians; oWinCount wraps after 65536 windows (forced preload allowed).
